stream_output_handler: RTL and testbench
========================================

// Module: stream_output_handler
// PURPOSE
//  Return path of the accelerator: takes alignment hits and end-of-query events from the Engine,
//  formats each as one 128-bit record, buffers it and drives the PCIe stream output.
//  Counts the hits accepted per query and reports that count in an end-of-query record.
//  Single clock domain (engine clock); the PCIe core crosses the output to the stream clock.
// PARAMETERS
//  DEPTH      16  record FIFO depth, power of two, >= 2
//  HIT_CNT_W  32  hit counter width, 1..32; the count is zero-extended into the done record
// PORTS
//  clk              in   1    engine clock, all logic on posedge
//  rst_n            in   1    asynchronous, active-low reset
//  hit_valid        in   1    hit record valid
//  hit_rdy          out  1    hit record accepted when hit_valid && hit_rdy
//  hit_query_id     in   16   query ID
//  hit_ref_pos      in   26   reference position of the cell
//  hit_query_pos    in   16   query position of the cell
//  hit_score        in   32   cell score
//  done_valid       in   1    end-of-query event valid
//  done_rdy         out  1    event accepted when done_valid && done_rdy
//  done_query_id    in   16   ID of the completed query
//  so_valid         out  1    stream output valid
//  so_data          out  128  stream output record
//  so_rdy           in   1    stream output ready; a record transfers when so_valid && so_rdy
//  busy             out  1    high while the FIFO is not empty
// BEHAVIOUR
//  Reset (async, rst_n=0): FIFO emptied, pointers/occupancy=0, hit_cnt=0. Outputs: so_valid=0,
//   busy=0, hit_rdy=1, done_rdy=1, so_data=0. Reset mid-transfer discards all buffered records.
//  HIT record:  [25:0]=ref_pos, [31:26]=0, [47:32]=query_pos, [59:48]=0, [63:60]=4'h1,
//   [79:64]=0, [95:80]=query_id, [127:96]=score.
//  DONE record: [31:0]=hit_cnt (zero-extended), [59:32]=0, [63:60]=4'h2, [79:64]=0,
//   [95:80]=done_query_id, [127:96]=0.
//  Input side (at most one FIFO write per cycle):
//   - hit_rdy  = (occupancy < DEPTH).
//   - done_rdy = (occupancy < DEPTH) && !hit_valid. A hit has priority, so a done event never
//     overtakes a hit presented in the same cycle.
//   - Hit accepted: write the HIT record; hit_cnt += 1, saturating at 2^HIT_CNT_W-1.
//   - Done accepted: write the DONE record carrying the current hit_cnt; hit_cnt <= 0 that cycle.
//   - hit_query_id is not checked against done_query_id.
//  Output side: first-word-fall-through FIFO.
//   - so_valid = (occupancy != 0); so_data = FIFO head; busy = so_valid.
//   - Latency: a record accepted at edge N gives so_valid=1 with that record after edge N.
//   - so_data stays stable while so_valid && !so_rdy. so_rdy has no combinational path to
//     hit_rdy or done_rdy.
//   - When so_data is not valid it holds the last value; it is 0 after reset.
//  Occupancy: write-only +1, read-only -1, write+read unchanged. When full, nothing is accepted
//   even if a read occurs in the same cycle; ready rises the cycle after the read.
//   Pointers wrap modulo DEPTH.
//  Records leave in exactly the order they were accepted; none are lost or duplicated.
//  FSM (per FIFO slot state, as seen by the output):
//   EMPTY -> HOLD on write; HOLD -> EMPTY on read with no write; HOLD -> FULL when
//   occupancy reaches DEPTH; FULL -> HOLD on read.
// TESTING
//  1. so_rdy=1; one hit (id=5, ref=0x123456, qpos=7, score=100) -> after next edge
//     so_data=0x00000064_0005_0000_1000_0007_00123456, transfers one cycle.
//  2. 3 hits for id 9, then done id 9 -> 4 records in order; DONE word[31:0]=3, [63:60]=2;
//     a following done with no hits reports 0.
//  3. so_rdy=0, DEPTH=16, continuous hits -> hit_rdy=0 after 16 accepts; so_data stable;
//     raise so_rdy -> all 16 drain in order, hit_rdy=1 the cycle after the first read.
//  4. hit_valid and done_valid high together -> done_rdy=0, hit written first; done accepted
//     the next cycle with a count that includes that hit.
//  5. HIT_CNT_W=4; 20 hits then done -> DONE count=15 (saturated).
//  6. rst_n low with 5 records buffered and so_valid=1 -> so_valid=0 immediately (async);
//     after release the next done reports count 0 and no stale records appear.

Source files
------------

// File: rtl/stream_output_handler.sv
// -----------------------------------------------------------------------------
// stream_output_handler
//
// Return path of the accelerator. Alignment hits and end-of-query events from
// the Engine are formatted into 128-bit records and pushed into a
// first-word-fall-through FIFO, which drives the PCIe stream output. The
// number of hits accepted since the last end-of-query event is counted and
// reported in the DONE record.
//
// Record layouts (unlisted bits are zero):
//   HIT : [25:0] ref_pos, [47:32] query_pos, [63:60] 4'h1,
//         [95:80] query_id, [127:96] score
//   DONE: [31:0] hit count (zero-extended), [63:60] 4'h2, [95:80] query_id
//
// Parameters
//   DEPTH      record FIFO depth, power of two, >= 2
//   HIT_CNT_W  hit counter width (1..32), saturates at all-ones
//
// Ports
//   clk, rst_n          engine clock, asynchronous active-low reset
//   hit_valid/hit_rdy   hit handshake, fields hit_query_id/ref_pos/query_pos/score
//   done_valid/done_rdy end-of-query handshake, field done_query_id
//   so_valid/so_rdy     stream output handshake, record on so_data
//   busy                high while the FIFO holds at least one record
// -----------------------------------------------------------------------------
module stream_output_handler #(
    parameter int DEPTH     = 16,
    parameter int HIT_CNT_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hit_valid,
    output logic         hit_rdy,
    input  logic [15:0]  hit_query_id,
    input  logic [25:0]  hit_ref_pos,
    input  logic [15:0]  hit_query_pos,
    input  logic [31:0]  hit_score,
    input  logic         done_valid,
    output logic         done_rdy,
    input  logic [15:0]  done_query_id,
    output logic         so_valid,
    output logic [127:0] so_data,
    input  logic         so_rdy,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [OW-1:0] OCC_ONE  = OW'(1);
    localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
    localparam logic [HIT_CNT_W-1:0] CNT_ONE = HIT_CNT_W'(1);

    // Fill state of the FIFO as seen by the output side.
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_HOLD,
        ST_FULL
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [127:0]         r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [OW-1:0]        r_occ;
    logic [HIT_CNT_W-1:0] r_hit_cnt;
    logic [127:0]         r_so_data;

    logic                 w_hit_rdy;
    logic                 w_done_rdy;
    logic                 w_so_valid;
    logic                 w_hit_acc;
    logic                 w_done_acc;
    logic                 w_wr;
    logic                 w_rd;
    logic [127:0]         w_wr_data;
    logic [OW-1:0]        w_occ_next;
    logic [AW-1:0]        w_rd_ptr_next;
    logic [127:0]         w_head_next;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block order.
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: handshakes and next state. Readiness depends on the registered
    // state only, so so_rdy never reaches hit_rdy/done_rdy combinationally;
    // a read on a full FIFO frees a slot only from the next cycle on.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block is assigned before any branch,
        // so no path can leave a value unassigned and infer a latch.
        w_state_next = r_state;
        w_hit_rdy    = (r_state != ST_FULL);
        // A presented hit blocks the done event so the done record can
        // never overtake a hit of the same cycle.
        w_done_rdy   = (r_state != ST_FULL) && !hit_valid;
        w_so_valid   = (r_state != ST_EMPTY);
        w_hit_acc    = hit_valid && w_hit_rdy;
        w_done_acc   = done_valid && w_done_rdy;
        w_wr         = w_hit_acc || w_done_acc;
        w_rd         = w_so_valid && so_rdy;

        unique case (r_state)
            ST_EMPTY: begin
                if (w_wr) w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_wr && !w_rd && (r_occ == OCC_FULL - OCC_ONE)) begin
                    w_state_next = ST_FULL;
                end else if (w_rd && !w_wr && (r_occ == OCC_ONE)) begin
                    w_state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_rd) w_state_next = ST_HOLD;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------
    // Record formatting, occupancy and next FIFO head
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_data = '0;
        if (w_hit_acc) begin
            w_wr_data = {hit_score, hit_query_id, 16'h0000, 4'h1, 12'h000,
                         hit_query_pos, 6'b000000, hit_ref_pos};
        end else if (w_done_acc) begin
            w_wr_data = {32'h0000_0000, done_query_id, 16'h0000, 4'h2, 28'h000_0000,
                         32'(r_hit_cnt)};
        end

        w_occ_next = r_occ;
        unique case ({w_wr, w_rd})
            2'b10:   w_occ_next = r_occ + OCC_ONE;
            2'b01:   w_occ_next = r_occ - OCC_ONE;
            default: w_occ_next = r_occ;
        endcase

        w_rd_ptr_next = r_rd_ptr + AW'(w_rd);

        // so_data is a register holding the head of the queue after this
        // edge. When the queue drains it keeps its last value. When the
        // written record becomes the head, it bypasses the memory.
        w_head_next = r_so_data;
        if (w_occ_next != '0) begin
            if (w_wr && ((r_occ == '0) || ((r_occ == OCC_ONE) && w_rd))) begin
                w_head_next = w_wr_data;
            end else begin
                w_head_next = r_mem[w_rd_ptr_next];
            end
        end
    end

    // ------------------------------------------------------------------
    // Record storage
    // ------------------------------------------------------------------
    // NOTE: the record array has no reset; a slot is only read after it has
    // been written, and keeping reset off the array lets it map to RAM.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, output register, hit counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_so_data <= '0;
            r_hit_cnt <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr  <= w_rd_ptr_next;
            r_occ     <= w_occ_next;
            r_so_data <= w_head_next;

            if (w_done_acc) begin
                r_hit_cnt <= '0;
            end else if (w_hit_acc && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + CNT_ONE;
            end
        end
    end

    assign hit_rdy  = w_hit_rdy;
    assign done_rdy = w_done_rdy;
    assign so_valid = w_so_valid;
    assign so_data  = r_so_data;
    assign busy     = w_so_valid;

endmodule

// File: tb/tb_stream_output_handler.sv
module tb_stream_output_handler;

    logic         clk;
    logic         rst_n;
    logic         hit_valid;
    logic [15:0]  hit_query_id;
    logic [25:0]  hit_ref_pos;
    logic [15:0]  hit_query_pos;
    logic [31:0]  hit_score;
    logic         done_valid;
    logic [15:0]  done_query_id;
    logic         so_rdy;

    logic         hit_rdy,  done_rdy,  so_valid,  busy;
    logic [127:0] so_data;
    logic         hit_rdy4, done_rdy4, so_valid4, busy4;
    logic [127:0] so_data4;

    int errors;
    int checks;

    logic [127:0] rx[$];
    logic [127:0] rx4[$];
    logic [127:0] exp[$];

    stream_output_handler #(.DEPTH(16), .HIT_CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .hit_valid(hit_valid), .hit_rdy(hit_rdy),
        .hit_query_id(hit_query_id), .hit_ref_pos(hit_ref_pos),
        .hit_query_pos(hit_query_pos), .hit_score(hit_score),
        .done_valid(done_valid), .done_rdy(done_rdy), .done_query_id(done_query_id),
        .so_valid(so_valid), .so_data(so_data), .so_rdy(so_rdy), .busy(busy)
    );

    // Same stimulus, narrow counter to exercise saturation.
    stream_output_handler #(.DEPTH(16), .HIT_CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .hit_valid(hit_valid), .hit_rdy(hit_rdy4),
        .hit_query_id(hit_query_id), .hit_ref_pos(hit_ref_pos),
        .hit_query_pos(hit_query_pos), .hit_score(hit_score),
        .done_valid(done_valid), .done_rdy(done_rdy4), .done_query_id(done_query_id),
        .so_valid(so_valid4), .so_data(so_data4), .so_rdy(so_rdy), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change only just after posedge, so a record seen valid and
    // ready at negedge transfers on the following posedge.
    always @(negedge clk) begin
        if (so_valid && so_rdy)  rx.push_back(so_data);
        if (so_valid4 && so_rdy) rx4.push_back(so_data4);
    end

    function automatic logic [127:0] hit_rec(input logic [15:0] id, input logic [25:0] rp,
                                             input logic [15:0] qp, input logic [31:0] sc);
        logic [127:0] r;
        r = '0;
        r[25:0]   = rp;
        r[47:32]  = qp;
        r[63:60]  = 4'h1;
        r[95:80]  = id;
        r[127:96] = sc;
        return r;
    endfunction

    function automatic logic [127:0] done_rec(input logic [15:0] id, input logic [31:0] cnt);
        logic [127:0] r;
        r = '0;
        r[31:0]  = cnt;
        r[63:60] = 4'h2;
        r[95:80] = id;
        return r;
    endfunction

    task automatic send_hit(input logic [15:0] id, input logic [25:0] rp,
                            input logic [15:0] qp, input logic [31:0] sc);
        logic acc;
        hit_valid = 1'b1;
        hit_query_id = id; hit_ref_pos = rp; hit_query_pos = qp; hit_score = sc;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            #1;
            acc = hit_rdy;
            @(posedge clk); #1;
        end
        hit_valid = 1'b0;
    endtask

    task automatic send_done(input logic [15:0] id);
        logic acc;
        done_valid = 1'b1;
        done_query_id = id;
        acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            #1;
            acc = done_rdy;
            @(posedge clk); #1;
        end
        done_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100; k++) begin
            if (!so_valid && !so_valid4) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_queues();
        rx.delete();
        rx4.delete();
        exp.delete();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        hit_valid = 1'b0; done_valid = 1'b0; so_rdy = 1'b0;
        hit_query_id = '0; hit_ref_pos = '0; hit_query_pos = '0; hit_score = '0;
        done_query_id = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (so_valid !== 1'b0) begin errors++; $display("FAIL reset_so_valid: got %b want 0", so_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (hit_rdy !== 1'b1) begin errors++; $display("FAIL reset_hit_rdy: got %b want 1", hit_rdy); end
        checks++; if (done_rdy !== 1'b1) begin errors++; $display("FAIL reset_done_rdy: got %b want 1", done_rdy); end
        checks++; if (so_data !== 128'h0) begin errors++; $display("FAIL reset_so_data: got %h want 0", so_data); end
        checks++; if (so_valid4 !== 1'b0 || so_data4 !== 128'h0) begin
            errors++; $display("FAIL reset_dut4: got valid=%b data=%h want 0/0", so_valid4, so_data4);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_hit();
        logic [127:0] want;
        want = 128'h00000064_0005_0000_1000_0007_00123456;
        so_rdy = 1'b1;
        clear_queues();
        send_hit(16'd5, 26'h123456, 16'd7, 32'd100);
        checks++; if (so_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b want 1", so_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy); end
        checks++; if (so_data !== want) begin errors++; $display("FAIL t1_data: got %h want %h", so_data, want); end
        @(posedge clk); #1;
        checks++; if (so_valid !== 1'b0) begin errors++; $display("FAIL t1_one_cycle: got valid=%b want 0", so_valid); end
        checks++; if (so_data !== want) begin errors++; $display("FAIL t1_hold: got %h want %h", so_data, want); end
        checks++; if (rx.size() != 1) begin errors++; $display("FAIL t1_count: got %0d want 1", rx.size()); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_done_count();
        so_rdy = 1'b1;
        clear_queues();
        send_done(16'd1);                                     exp.push_back(done_rec(16'd1, 32'd1));
        send_hit(16'd9, 26'h10, 16'd1, 32'hA1);               exp.push_back(hit_rec(16'd9, 26'h10, 16'd1, 32'hA1));
        send_hit(16'd9, 26'h20, 16'd2, 32'hA2);               exp.push_back(hit_rec(16'd9, 26'h20, 16'd2, 32'hA2));
        send_hit(16'd9, 26'h3FFFFFF, 16'hFFFF, 32'hFFFFFFFF); exp.push_back(hit_rec(16'd9, 26'h3FFFFFF, 16'hFFFF, 32'hFFFFFFFF));
        send_done(16'd9);                                     exp.push_back(done_rec(16'd9, 32'd3));
        send_done(16'd9);                                     exp.push_back(done_rec(16'd9, 32'd0));
        wait_drain();
        checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL t2_count: got %0d want %0d", rx.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp[i]) begin
                errors++; $display("FAIL t2_rec%0d: got %h want %h", i, (i < rx.size()) ? rx[i] : 128'hx, exp[i]);
            end
        end
        if (rx.size() >= 5) begin
            checks++; if (rx[4][31:0] !== 32'd3 || rx[4][63:60] !== 4'h2) begin
                errors++; $display("FAIL t2_done_fields: got cnt=%0d tag=%h want 3/2", rx[4][31:0], rx[4][63:60]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        int accepts;
        int unstable;
        logic [127:0] head0;
        so_rdy = 1'b0;
        clear_queues();
        accepts = 0; unstable = 0; head0 = '0;
        hit_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            hit_query_id = 16'h30; hit_ref_pos = 26'(i * 3 + 1);
            hit_query_pos = 16'(i); hit_score = 32'(1000 + i);
            #1;
            if (hit_rdy) begin
                exp.push_back(hit_rec(16'h30, 26'(i * 3 + 1), 16'(i), 32'(1000 + i)));
                accepts++;
            end
            @(posedge clk); #1;
            if (i == 0) head0 = so_data;
            else if (so_data !== head0) unstable++;
        end
        checks++; if (accepts != 16) begin errors++; $display("FAIL t3_accepts: got %0d want 16", accepts); end
        checks++; if (hit_rdy !== 1'b0) begin errors++; $display("FAIL t3_full_rdy: got %b want 0", hit_rdy); end
        checks++; if (so_valid !== 1'b1) begin errors++; $display("FAIL t3_valid: got %b want 1", so_valid); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL t3_stable: got %0d changes want 0", unstable); end
        checks++; if (head0 !== hit_rec(16'h30, 26'd1, 16'd0, 32'd1000)) begin
            errors++; $display("FAIL t3_head: got %h want %h", head0, hit_rec(16'h30, 26'd1, 16'd0, 32'd1000));
        end
        // Hit still presented while the first read happens: it must not be taken.
        so_rdy = 1'b1;
        #1;
        checks++; if (hit_rdy !== 1'b0) begin errors++; $display("FAIL t3_rdy_no_comb: got %b want 0", hit_rdy); end
        @(posedge clk); #1;
        checks++; if (hit_rdy !== 1'b1) begin errors++; $display("FAIL t3_rdy_after_read: got %b want 1", hit_rdy); end
        hit_valid = 1'b0;
        wait_drain();
        checks++; if (rx.size() != 16) begin errors++; $display("FAIL t3_drain_count: got %0d want 16", rx.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp[i]) begin
                errors++; $display("FAIL t3_rec%0d: got %h want %h", i, (i < rx.size()) ? rx[i] : 128'hx, exp[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority();
        so_rdy = 1'b1;
        clear_queues();
        send_done(16'd2);
        exp.push_back(done_rec(16'd2, 32'd16));
        hit_valid = 1'b1; hit_query_id = 16'h33; hit_ref_pos = 26'h55; hit_query_pos = 16'h66; hit_score = 32'h77;
        done_valid = 1'b1; done_query_id = 16'h33;
        #1;
        checks++; if (done_rdy !== 1'b0) begin errors++; $display("FAIL t4_done_blocked: got %b want 0", done_rdy); end
        checks++; if (hit_rdy !== 1'b1) begin errors++; $display("FAIL t4_hit_rdy: got %b want 1", hit_rdy); end
        @(posedge clk); #1;
        hit_valid = 1'b0;
        #1;
        checks++; if (done_rdy !== 1'b1) begin errors++; $display("FAIL t4_done_rdy: got %b want 1", done_rdy); end
        @(posedge clk); #1;
        done_valid = 1'b0;
        exp.push_back(hit_rec(16'h33, 26'h55, 16'h66, 32'h77));
        exp.push_back(done_rec(16'h33, 32'd1));
        wait_drain();
        checks++; if (rx.size() != exp.size()) begin errors++; $display("FAIL t4_count: got %0d want %0d", rx.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= rx.size() || rx[i] !== exp[i]) begin
                errors++; $display("FAIL t4_rec%0d: got %h want %h", i, (i < rx.size()) ? rx[i] : 128'hx, exp[i]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturate();
        so_rdy = 1'b1;
        clear_queues();
        for (int i = 0; i < 20; i++) send_hit(16'h50, 26'(i), 16'(i), 32'(i));
        send_done(16'h77);
        wait_drain();
        checks++; if (rx4.size() != 21) begin errors++; $display("FAIL t5_count4: got %0d want 21", rx4.size()); end
        checks++; if (rx4.size() == 0 || rx4[rx4.size() - 1] !== done_rec(16'h77, 32'd15)) begin
            errors++; $display("FAIL t5_sat: got %h want %h", (rx4.size() > 0) ? rx4[rx4.size() - 1] : 128'hx, done_rec(16'h77, 32'd15));
        end
        checks++; if (rx.size() == 0 || rx[rx.size() - 1] !== done_rec(16'h77, 32'd20)) begin
            errors++; $display("FAIL t5_wide: got %h want %h", (rx.size() > 0) ? rx[rx.size() - 1] : 128'hx, done_rec(16'h77, 32'd20));
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        so_rdy = 1'b0;
        clear_queues();
        for (int i = 0; i < 5; i++) send_hit(16'h60, 26'(i + 100), 16'(i), 32'(i + 7));
        checks++; if (so_valid !== 1'b1) begin errors++; $display("FAIL t6_buffered: got %b want 1", so_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (so_valid !== 1'b0) begin errors++; $display("FAIL t6_async_valid: got %b want 0", so_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t6_async_busy: got %b want 0", busy); end
        checks++; if (so_data !== 128'h0) begin errors++; $display("FAIL t6_async_data: got %h want 0", so_data); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        so_rdy = 1'b1;
        clear_queues();
        send_done(16'h44);
        wait_drain();
        checks++; if (rx.size() != 1) begin errors++; $display("FAIL t6_count: got %0d want 1", rx.size()); end
        checks++; if (rx.size() == 0 || rx[0] !== done_rec(16'h44, 32'd0)) begin
            errors++; $display("FAIL t6_done: got %h want %h", (rx.size() > 0) ? rx[0] : 128'hx, done_rec(16'h44, 32'd0));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_hit();
        test_done_count();
        test_full();
        test_priority();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
